// File: rtl/psk_demodulator_if.sv
// ============================================================================
// Module   : psk_demodulator_if
// Purpose  : Serial-in / FIFO-out bundle of the PSK symbol demodulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface psk_demodulator_if;
    logic       enable;
    logic       rx_in;
    logic       full;
    logic [7:0] data;
    logic       write;
    logic       locked;
    logic       overflow;
    logic       symb_clk;

    modport master (
        output enable, rx_in, full,
        input  data, write, locked, overflow, symb_clk
    );

    modport slave (
        input  enable, rx_in, full,
        output data, write, locked, overflow, symb_clk
    );
endinterface

`default_nettype wire

// File: rtl/psk_demodulator.sv
// ============================================================================
// Module   : psk_demodulator
// Purpose  : Recovers bit timing from a serial line, hunts for a sync byte and
//            assembles fixed-length frames of symbols into FIFO writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module psk_demodulator #(
    parameter int         PSK_CLKS_PER_BIT    = 4,
    parameter int         PSK_BITS_PER_SYMBOL = 4,
    parameter logic [7:0] SYNC_WORD           = 8'hA5,
    parameter int         FRAME_SYMBOLS       = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    psk_demodulator_if.slave  psk
);

    localparam int CNT_W = $clog2(PSK_CLKS_PER_BIT);
    localparam int BIT_W = (PSK_BITS_PER_SYMBOL > 1) ? $clog2(PSK_BITS_PER_SYMBOL) : 1;
    localparam int SYM_W = (FRAME_SYMBOLS > 1) ? $clog2(FRAME_SYMBOLS) : 1;

    localparam logic [CNT_W-1:0] c_cnt_half = CNT_W'(PSK_CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(PSK_CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(PSK_BITS_PER_SYMBOL - 1);
    localparam logic [SYM_W-1:0] c_sym_last = SYM_W'(FRAME_SYMBOLS - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'b01,
        LOCKED = 2'b10
    } state_t;

    logic             rx_meta_q;
    logic             rx_s_q;
    logic             rx_prev_q;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    state_t           state_q,    state_d;
    logic [7:0]       hunt_q,     hunt_d;
    logic [7:0]       sym_q,      sym_d;
    logic [BIT_W-1:0] bit_cnt_q,  bit_cnt_d;
    logic [SYM_W-1:0] sym_cnt_q,  sym_cnt_d;
    logic [7:0]       data_q,     data_d;
    logic             write_q,    write_d;
    logic             overflow_q, overflow_d;
    logic             symb_clk_q, symb_clk_d;
    logic             w_bit_valid;
    logic [7:0]       w_sym;

    // rx_prev keeps tracking while enable is low so a transition that happened
    // during the pause is never seen as a fresh edge afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b0;
            rx_s_q    <= 1'b0;
            rx_prev_q <= 1'b0;
        end else begin
            rx_meta_q <= psk.rx_in;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (psk.enable) begin
            if (rx_s_q != rx_prev_q) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q == c_cnt_last) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign w_bit_valid = psk.enable && (cnt_q == c_cnt_half);

    always_comb begin
        state_d    = state_q;
        hunt_d     = hunt_q;
        sym_d      = sym_q;
        bit_cnt_d  = bit_cnt_q;
        sym_cnt_d  = sym_cnt_q;
        data_d     = data_q;
        write_d    = 1'b0;
        overflow_d = overflow_q;
        symb_clk_d = symb_clk_q;
        w_sym      = sym_q;
        case (state_q)
            HUNT: begin
                if (psk.enable) begin
                    if (hunt_q == SYNC_WORD) begin
                        state_d   = LOCKED;
                        bit_cnt_d = '0;
                        sym_cnt_d = '0;
                        sym_d     = '0;
                    end else if (w_bit_valid) begin
                        hunt_d = {rx_s_q, hunt_q[7:1]};
                    end
                end
            end
            LOCKED: begin
                if (w_bit_valid) begin
                    w_sym[bit_cnt_q] = rx_s_q;
                    sym_d            = w_sym;
                    bit_cnt_d        = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == c_bit_last) begin
                        bit_cnt_d  = '0;
                        sym_d      = '0;
                        symb_clk_d = ~symb_clk_q;
                        if (!psk.full) begin
                            write_d = 1'b1;
                            data_d  = w_sym;
                        end else begin
                            overflow_d = 1'b1;
                        end
                        // Last symbol of the frame: go back to hunting with a clean window.
                        if (sym_cnt_q == c_sym_last) begin
                            state_d   = HUNT;
                            hunt_d    = '0;
                            sym_cnt_d = '0;
                        end else begin
                            sym_cnt_d = sym_cnt_q + SYM_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            state_q    <= HUNT;
            hunt_q     <= '0;
            sym_q      <= '0;
            bit_cnt_q  <= '0;
            sym_cnt_q  <= '0;
            data_q     <= '0;
            write_q    <= 1'b0;
            overflow_q <= 1'b0;
            symb_clk_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            hunt_q     <= hunt_d;
            sym_q      <= sym_d;
            bit_cnt_q  <= bit_cnt_d;
            sym_cnt_q  <= sym_cnt_d;
            data_q     <= data_d;
            write_q    <= write_d;
            overflow_q <= overflow_d;
            symb_clk_q <= symb_clk_d;
        end
    end

    assign psk.data     = data_q;
    assign psk.write    = write_q;
    assign psk.locked   = (state_q == LOCKED);
    assign psk.overflow = overflow_q;
    assign psk.symb_clk = symb_clk_q;

endmodule

`default_nettype wire

// File: tb/tb_psk_demodulator.sv
// ============================================================================
// Module   : tb_psk_demodulator
// Purpose  : Directed scenarios for psk_demodulator with default parameters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_psk_demodulator;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    psk_demodulator_if bus ();

    psk_demodulator #(
        .PSK_CLKS_PER_BIT    (4),
        .PSK_BITS_PER_SYMBOL (4),
        .SYNC_WORD           (8'hA5),
        .FRAME_SYMBOLS       (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .psk (bus.slave)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] wq[$];
    int         toggles = 0;
    logic       sclk_prev = 1'b0;

    // Record every FIFO write and every symb_clk transition.
    always @(negedge clk) begin
        if (bus.write === 1'b1) wq.push_back(bus.data);
        if (bus.symb_clk !== sclk_prev) toggles++;
        sclk_prev = bus.symb_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, time=%0t required end before 200000", $time);
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.rx_in = b;
        idle(4);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic send_nib(input logic [3:0] v);
        for (int i = 0; i < 4; i++) send_bit(v[i]);
    endtask

    task automatic do_reset();
        bus.enable = 1'b1;
        bus.full   = 1'b0;
        bus.rx_in  = 1'b0;
        rst        = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus.data); end
        checks++; if (bus.write !== 1'b0) begin errors++; $display("FAIL reset_write got %b want 0", bus.write); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", bus.locked); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
        checks++; if (bus.symb_clk !== 1'b0) begin errors++; $display("FAIL reset_symb_clk got %b want 0", bus.symb_clk); end
    endtask

    task automatic test_basic();
        int wb, tb0;
        do_reset();
        wb = wq.size(); tb0 = toggles;
        send_byte(8'hA5);
        send_nib(4'h3);
        send_nib(4'hC);
        idle(4);
        checks++; if (wq.size() - wb !== 2) begin errors++; $display("FAIL basic_count got %0d want 2", wq.size() - wb); end
        if (wq.size() - wb >= 2) begin
            checks++; if (wq[wb] !== 8'h03) begin errors++; $display("FAIL basic_data0 got %h want 03", wq[wb]); end
            checks++; if (wq[wb+1] !== 8'h0C) begin errors++; $display("FAIL basic_data1 got %h want 0c", wq[wb+1]); end
        end
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL basic_locked got %b want 1", bus.locked); end
        checks++; if (toggles - tb0 !== 2) begin errors++; $display("FAIL basic_symb_clk toggles got %0d want 2", toggles - tb0); end
    endtask

    task automatic test_sync();
        do_reset();
        send_byte(8'hA4);
        idle(4);
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL sync_a4_nolock got %b want 0", bus.locked); end
        send_byte(8'hA5);
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL sync_early got %b want 0", bus.locked); end
        idle(2);
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL sync_lock got %b want 1", bus.locked); end
    endtask

    task automatic test_frame();
        int wb;
        do_reset();
        wb = wq.size();
        send_byte(8'hA5);
        for (int s = 0; s < 16; s++) send_nib(s[3:0]);
        idle(2);
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL frame_unlock got %b want 0", bus.locked); end
        checks++; if (wq.size() - wb !== 16) begin errors++; $display("FAIL frame_count got %0d want 16", wq.size() - wb); end
        if (wq.size() - wb >= 16) begin
            for (int s = 0; s < 16; s++) begin
                checks++;
                if (wq[wb+s] !== 8'(s)) begin errors++; $display("FAIL frame_data[%0d] got %h want %h", s, wq[wb+s], 8'(s)); end
            end
        end
        send_nib(4'h6);
        idle(4);
        checks++; if (wq.size() - wb !== 16) begin errors++; $display("FAIL frame_ignore count got %0d want 16", wq.size() - wb); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL frame_relock got %b want 0", bus.locked); end
    endtask

    task automatic test_overflow();
        int wb, tb0;
        do_reset();
        wb = wq.size(); tb0 = toggles;
        send_byte(8'hA5);
        send_nib(4'h1);
        send_bit(1'b0);
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", bus.overflow); end
        bus.full = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        bus.full = 1'b0;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        idle(4);
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", bus.overflow); end
        checks++; if (toggles - tb0 !== 3) begin errors++; $display("FAIL ovf_symb_clk toggles got %0d want 3", toggles - tb0); end
        checks++; if (wq.size() - wb !== 2) begin errors++; $display("FAIL ovf_count got %0d want 2", wq.size() - wb); end
        if (wq.size() - wb >= 2) begin
            checks++; if (wq[wb] !== 8'h01) begin errors++; $display("FAIL ovf_data0 got %h want 01", wq[wb]); end
            checks++; if (wq[wb+1] !== 8'h03) begin errors++; $display("FAIL ovf_data1 got %h want 03", wq[wb+1]); end
        end
        send_nib(4'h4);
        idle(4);
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", bus.overflow); end
    endtask

    task automatic test_enable();
        int wb, tb0;
        do_reset();
        send_byte(8'hA5);
        wb = wq.size(); tb0 = toggles;
        send_bit(1'b0);
        send_bit(1'b1);
        bus.rx_in = 1'b0;
        idle(2);
        bus.enable = 1'b0;
        idle(10);
        checks++; if (wq.size() - wb !== 0) begin errors++; $display("FAIL en_nowrite got %0d want 0", wq.size() - wb); end
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL en_locked got %b want 1", bus.locked); end
        bus.enable = 1'b1;
        idle(2);
        send_bit(1'b1);
        send_nib(4'h5);
        idle(4);
        checks++; if (wq.size() - wb !== 2) begin errors++; $display("FAIL en_count got %0d want 2", wq.size() - wb); end
        if (wq.size() - wb >= 2) begin
            checks++; if (wq[wb] !== 8'h0A) begin errors++; $display("FAIL en_data0 got %h want 0a", wq[wb]); end
            checks++; if (wq[wb+1] !== 8'h05) begin errors++; $display("FAIL en_data1 got %h want 05", wq[wb+1]); end
        end
        checks++; if (toggles - tb0 !== 2) begin errors++; $display("FAIL en_symb_clk toggles got %0d want 2", toggles - tb0); end
    endtask

    task automatic test_reset_mid();
        int wb;
        do_reset();
        wb = wq.size();
        send_byte(8'hA5);
        send_nib(4'h9);
        send_bit(1'b0);
        send_bit(1'b1);
        bus.rx_in = 1'b1;
        idle(2);
        checks++; if (wq.size() - wb !== 1) begin errors++; $display("FAIL rmid_pre_count got %0d want 1", wq.size() - wb); end
        checks++; if (bus.data !== 8'h09) begin errors++; $display("FAIL rmid_pre_data got %h want 09", bus.data); end
        rst = 1'b1;
        idle(1);
        checks++; if (bus.data !== 8'h00) begin errors++; $display("FAIL rmid_data got %h want 00", bus.data); end
        checks++; if (bus.write !== 1'b0) begin errors++; $display("FAIL rmid_write got %b want 0", bus.write); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL rmid_locked got %b want 0", bus.locked); end
        checks++; if (bus.symb_clk !== 1'b0) begin errors++; $display("FAIL rmid_symb_clk got %b want 0", bus.symb_clk); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rmid_overflow got %b want 0", bus.overflow); end
        rst = 1'b0;
        wb = wq.size();
        send_bit(1'b0);
        idle(8);
        checks++; if (wq.size() - wb !== 0) begin errors++; $display("FAIL rmid_discard got %0d want 0", wq.size() - wb); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL rmid_nolock got %b want 0", bus.locked); end
        send_byte(8'hA5);
        send_nib(4'h7);
        idle(4);
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL rmid_relock got %b want 1", bus.locked); end
        checks++; if (wq.size() - wb !== 1) begin errors++; $display("FAIL rmid_post_count got %0d want 1", wq.size() - wb); end
        if (wq.size() - wb >= 1) begin
            checks++; if (wq[wb] !== 8'h07) begin errors++; $display("FAIL rmid_post_data got %h want 07", wq[wb]); end
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.enable = 1'b1;
        bus.full   = 1'b0;
        bus.rx_in  = 1'b0;
        test_reset();
        test_basic();
        test_sync();
        test_frame();
        test_overflow();
        test_enable();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/psk_demodulator.md
PSK_DEMODULATOR -- requirements
Module: psk_demodulator

Interface
REQ-001 SHALL have parameter PSK_CLKS_PER_BIT, default 4, clocks per serial bit (legal >= 4).
REQ-002 SHALL have parameter PSK_BITS_PER_SYMBOL, default 4, bits per symbol (legal 1..8).
REQ-003 SHALL have parameter SYNC_WORD, default 8'hA5, 8-bit frame sync pattern, transmitted LSB first.
REQ-004 SHALL have parameter FRAME_SYMBOLS, default 16, symbols per frame after sync (legal >= 1).
REQ-005 SHALL have clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have enable  input  1  advance enable; low freezes all state except the synchronizer.
REQ-008 SHALL have rx_in  input  1  asynchronous serial line, LSB-first bits, PSK_CLKS_PER_BIT clocks each.
REQ-009 SHALL have full  input  1  downstream FIFO full.
REQ-010 SHALL have data  output  8  received symbol, zero-extended above PSK_BITS_PER_SYMBOL.
REQ-011 SHALL have write  output  1  one-cycle FIFO write strobe; data valid when high.
REQ-012 SHALL have locked  output  1  high in state LOCKED.
REQ-013 SHALL have overflow  output  1  sticky; set when a symbol is dropped on full.
REQ-014 SHALL have symb_clk  output  1  toggles once per completed symbol (written or dropped).

Function
REQ-015 rx_in SHALL pass a 2-FF synchronizer (rx_s); rx_prev SHALL hold the previous rx_s.
REQ-016 Edge: rx_s != rx_prev with enable high SHALL load phase counter with 1; otherwise counter SHALL increment, wrapping PSK_CLKS_PER_BIT-1 -> 0.
REQ-017 Bit sample: when counter == PSK_CLKS_PER_BIT/2 and enable high, rx_s SHALL be taken as the bit (bit_valid, one per bit period).
REQ-018 States SHALL be HUNT and LOCKED only; any other encoding SHALL return to HUNT.
REQ-019 HUNT: each sampled bit SHALL shift into bit 7 of an 8-bit hunt register (right shift).
REQ-020 HUNT: the cycle after the hunt register equals SYNC_WORD, state SHALL be LOCKED, bit and symbol counters 0; the sync bits SHALL not be output.
REQ-021 LOCKED: sampled bit k (k = 0..PSK_BITS_PER_SYMBOL-1) SHALL be stored at symbol bit k.
REQ-022 On sampling the last bit of a symbol at cycle T: at T+1 data SHALL hold the full symbol including that bit and write SHALL be 1 if full was 0 at T.
REQ-023 If full was 1 at T: write SHALL stay 0, data SHALL not update, overflow SHALL set; symbol dropped.
REQ-024 symb_clk SHALL toggle at T+1 for every completed symbol.
REQ-025 Completion of symbol FRAME_SYMBOLS-1 SHALL return to HUNT with hunt register cleared to 0 at T+1.
REQ-026 write SHALL be 0 in every cycle not covered by REQ-022.
REQ-027 enable low SHALL hold counters, state, data, locked, overflow, symb_clk; write SHALL be 0; an edge during enable low SHALL not realign.
REQ-028 Total latency: rx_in change to rx_s SHALL be 2 cycles.
REQ-029 Frame boundary: sync detection SHALL resume with the first bit sampled after return to HUNT.

Reset
REQ-030 rst SHALL override enable and take effect at the next edge, including mid-symbol.
REQ-031 Reset values: state HUNT, synchronizer 0, rx_prev 0, counter 0, hunt register 0, symbol register 0, data 0, write 0, locked 0, overflow 0, symb_clk 0.
REQ-032 A partially received symbol at reset SHALL be discarded, never written.

Verification
REQ-033 Defaults; send 8'hA5 LSB first then nibbles 3,C -> write pulses with data 8'h03 then 8'h0C, locked 1, symb_clk toggles twice.
REQ-034 Send 0xA4 then 0xA5 -> no lock on 0xA4; locked rises one cycle after the eighth bit of 0xA5.
REQ-035 Sync then 16 symbols 0..F -> 16 writes data 0x00..0x0F in order; locked falls after the 16th; next nibble ignored until new sync.
REQ-036 full=1 during completion of symbol 2 -> no write for it, overflow=1 and stays 1, symb_clk still toggles, symbols 1 and 3 written.
REQ-037 enable low 10 cycles mid-symbol, then high -> symbol value unchanged, no spurious write, timing resumes.
REQ-038 rst during bit 2 of a symbol -> all outputs to reset values next cycle, no write; relock required via 0xA5.
